uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DIVISOR, default 104, meaning clk cycles per UART bit (12 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO entries; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port lpc_rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_stb  input  1  one-cycle write strobe from the LPC I/O-write decode of 0x03F8 (THR).
REQ-006 SHALL have port wr_data  input  8  byte to transmit, valid when wr_stb=1.
REQ-007 SHALL have port clr_ovr  input  1  one-cycle clear of the overrun flag.
REQ-008 SHALL have port uart_tx  output  1  serial line, idle high.
REQ-009 SHALL have port thre  output  1  FIFO empty, for LSR bit 5 at 0x03FD.
REQ-010 SHALL have port temt  output  1  FIFO empty and shifter idle, for LSR bit 6.
REQ-011 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-012 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO entry count.
REQ-013 SHALL have port overrun  output  1  sticky flag: a write was dropped.

Function
REQ-014 SHALL accept a write on wr_stb=1 when full=0, or when full=1 and a pop occurs in the same cycle; level SHALL update on the next cycle.
REQ-015 SHALL drop a write when full=1 and no pop occurs, set overrun on the next cycle, and leave FIFO contents unchanged.
REQ-016 SHALL give clr_ovr priority below a same-cycle overrun event: overrun SHALL stay 1.
REQ-017 SHALL implement serializer states IDLE, START, DATA, STOP; START, each DATA bit, and STOP SHALL each last exactly DIVISOR cycles.
REQ-018 In IDLE with level>0, SHALL pop the head byte; state SHALL be START and uart_tx=0 from the next cycle.
REQ-019 DATA SHALL send 8 bits LSB first; STOP SHALL drive uart_tx=1; no parity bit (8N1); a frame SHALL be 10*DIVISOR cycles.
REQ-020 On the last STOP cycle with level>0, SHALL pop and enter START directly, giving zero idle gap between frames; otherwise SHALL enter IDLE.
REQ-021 Write-to-start-bit latency from an empty FIFO in IDLE SHALL be 2 cycles (wr_stb at N, pop at N+1, uart_tx=0 at N+2).
REQ-022 uart_tx SHALL be driven from a register and be glitch-free.
REQ-023 thre SHALL equal (level==0); temt SHALL equal thre AND state==IDLE; full SHALL equal (level==DEPTH).
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or underflow.

Reset
REQ-025 lpc_rst=0 SHALL asynchronously force uart_tx=1, state=IDLE, level=0, pointers=0, overrun=0, thre=1, temt=1, full=0, and clear the bit and baud counters.
REQ-026 A reset mid-frame SHALL abort the frame immediately (uart_tx=1) and discard all queued bytes.
REQ-027 Reset release SHALL be synchronized inside the block; the first write SHALL be accepted on the second clk edge after deassertion.

Structure
REQ-028 Serializer state encoding, DIVISOR default and DEPTH default SHALL live in shared header uart_defs, which the LPC decoder also uses for the LSR bit positions.
REQ-029 Storage and pointers SHALL be a sub-module sync_fifo; the baud counter, bit counter and shifter SHALL be in uart_tx_fifo.

Verification (DIVISOR=4, DEPTH=16)
REQ-030 Write 0x5A at cycle N -> uart_tx=0 at N+2; bits 0,1,0,1,1,0,1,0 of 4 cycles each; then high; temt=1 at N+42.
REQ-031 Writes 0x5A then 0xA5 on consecutive cycles -> two frames with zero idle gap, 80 cycles total; thre=1 after the second pop.
REQ-032 17 writes during the first frame -> level=15 after the first pop; 17th write dropped; overrun=1; clr_ovr -> overrun=0 next cycle.
REQ-033 FIFO full and wr_stb coincident with a STOP-end pop -> write accepted, level stays 16, overrun stays 0.
REQ-034 lpc_rst pulsed low during DATA bit 3 -> uart_tx=1 immediately, level=0, thre=temt=1; next write 0xA5 transmits correctly.

Source files
------------

// File: rtl/uart_defs.sv
// Shared UART definitions: serializer state encoding, parameter defaults and LSR bit positions.
// The LPC decoder imports this too so both sides agree on the LSR layout.
package uart_defs;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  localparam int unsigned DivisorDefault = 104;  // 12 MHz / 115200
  localparam int unsigned DepthDefault   = 16;

  localparam int unsigned LsrThreBit = 5;
  localparam int unsigned LsrTemtBit = 6;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read; pointers wrap modulo DEPTH (power of two).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned LvlW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [PtrW:0]    level_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [PtrW:0] LevelFull = LvlW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LevelFull);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO, for the LPC-mapped THR/LSR at 0x03F8/0x03FD.
// Back-to-back frames have no idle gap: the next byte is popped on the last STOP cycle.
module uart_tx_fifo
  import uart_defs::*;
#(
  parameter int unsigned DIVISOR = DivisorDefault,
  parameter int unsigned DEPTH   = DepthDefault
) (
  input  logic                    clk,
  input  logic                    lpc_rst,
  input  logic                    wr_stb,
  input  logic [7:0]              wr_data,
  input  logic                    clr_ovr,
  output logic                    uart_tx,
  output logic                    thre,
  output logic                    temt,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overrun
);

  localparam logic [15:0] BaudLast = 16'(DIVISOR - 1);

  // Asserts asynchronously, releases on the first edge so the second edge can accept a write.
  logic rst_sync_q;
  always_ff @(posedge clk or negedge lpc_rst) begin
    if (!lpc_rst) rst_sync_q <= 1'b0;
    else          rst_sync_q <= 1'b1;
  end

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        overrun_q, overrun_d;
  logic        pop, fifo_empty, fifo_full, baud_end;
  logic [7:0]  head;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_sync_q),
    .push_i  (wr_stb),
    .wdata_i (wr_data),
    .pop_i   (pop),
    .rdata_o (head),
    .level_o (level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign baud_end = (baud_q == BaudLast);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = '0;
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = StStart;
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  // A dropped write wins over a same-cycle clear.
  always_comb begin
    overrun_d = overrun_q;
    if (wr_stb && fifo_full && !pop) overrun_d = 1'b1;
    else if (clr_ovr)                overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      overrun_q <= overrun_d;
    end
  end

  assign uart_tx = tx_q;
  assign thre    = fifo_empty;
  assign temt    = fifo_empty && (state_q == StIdle);
  assign full    = fifo_full;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with DIVISOR=4, DEPTH=16: framing, back-to-back frames,
// overrun handling, full-FIFO write coincident with a pop, and mid-frame reset.
module tb_uart_tx_fifo;

  localparam int unsigned Div = 4;
  localparam int unsigned Dep = 16;

  logic       clk = 1'b0;
  logic       lpc_rst;
  logic       wr_stb;
  logic [7:0] wr_data;
  logic       clr_ovr;
  logic       uart_tx, thre, temt, full, overrun;
  logic [4:0] level;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DIVISOR (Div),
    .DEPTH   (Dep)
  ) dut (
    .clk     (clk),
    .lpc_rst (lpc_rst),
    .wr_stb  (wr_stb),
    .wr_data (wr_data),
    .clr_ovr (clr_ovr),
    .uart_tx (uart_tx),
    .thre    (thre),
    .temt    (temt),
    .full    (full),
    .level   (level),
    .overrun (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Entered on the first START cycle; leaves on the cycle after the last STOP cycle.
  task automatic check_frame(input string tag, input logic [7:0] b);
    logic [9:0] seq;
    seq = {1'b1, b, 1'b0};
    for (int c = 0; c < 40; c++) begin
      check($sformatf("%s_c%0d", tag, c), 32'(uart_tx), 32'(seq[c / 4]));
      tick();
    end
  endtask

  initial begin
    lpc_rst = 1'b0;
    wr_stb  = 1'b0;
    wr_data = 8'h00;
    clr_ovr = 1'b0;
    #12;
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_thre", 32'(thre), 32'd1);
    check("rst_temt", 32'(temt), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);

    // Release with a write already pending: edge 1 ignores it, edge 2 accepts it.
    tick();
    lpc_rst = 1'b1;
    wr_stb  = 1'b1;
    wr_data = 8'h5A;
    tick();
    check("rel_edge1_level", 32'(level), 32'd0);
    tick();
    check("rel_edge2_level", 32'(level), 32'd1);
    check("rel_edge2_thre", 32'(thre), 32'd0);
    check("latency_tx_n1", 32'(uart_tx), 32'd1);
    wr_stb = 1'b0;
    tick();
    check("f5a_temt_busy", 32'(temt), 32'd0);
    check_frame("f5a", 8'h5A);
    check("f5a_temt_n42", 32'(temt), 32'd1);
    check("f5a_idle_tx", 32'(uart_tx), 32'd1);

    // Two writes on consecutive cycles: two frames with no gap.
    wr_stb  = 1'b1;
    wr_data = 8'h5A;
    tick();
    wr_data = 8'hA5;
    tick();
    wr_stb = 1'b0;
    check("b2b_level", 32'(level), 32'd1);
    check_frame("b2b_0", 8'h5A);
    check("b2b_thre", 32'(thre), 32'd1);
    check("b2b_temt", 32'(temt), 32'd0);
    check_frame("b2b_1", 8'hA5);
    check("b2b_temt_end", 32'(temt), 32'd1);

    // Fill the FIFO during the first frame, overflow it, then refill on the STOP-end pop.
    wr_stb  = 1'b1;
    wr_data = 8'h30;
    tick();
    wr_stb = 1'b0;
    tick();
    for (int i = 1; i <= 16; i++) begin
      wr_stb  = 1'b1;
      wr_data = 8'(8'h30 + i);
      tick();
    end
    check("fill_level", 32'(level), 32'd16);
    check("fill_full", 32'(full), 32'd1);
    check("fill_ovr", 32'(overrun), 32'd0);
    wr_data = 8'hEE;
    tick();
    check("drop_ovr", 32'(overrun), 32'd1);
    check("drop_level", 32'(level), 32'd16);
    wr_data = 8'hDD;
    clr_ovr = 1'b1;
    tick();
    check("drop_clr_ovr", 32'(overrun), 32'd1);
    check("drop_clr_level", 32'(level), 32'd16);
    wr_stb = 1'b0;
    tick();
    check("clr_ovr", 32'(overrun), 32'd0);
    clr_ovr = 1'b0;
    repeat (20) tick();
    wr_stb  = 1'b1;
    wr_data = 8'hC3;
    tick();
    wr_stb = 1'b0;
    check("popw_level", 32'(level), 32'd16);
    check("popw_full", 32'(full), 32'd1);
    check("popw_ovr", 32'(overrun), 32'd0);
    for (int i = 1; i <= 16; i++) check_frame($sformatf("drain%0d", i), 8'(8'h30 + i));
    check_frame("drain_c3", 8'hC3);
    check("drain_temt", 32'(temt), 32'd1);
    check("drain_level", 32'(level), 32'd0);

    // Reset during DATA bit 3 of 0x35 (bit 3 = 0) with another byte queued.
    wr_stb  = 1'b1;
    wr_data = 8'h35;
    tick();
    wr_data = 8'h81;
    tick();
    wr_stb = 1'b0;
    repeat (17) tick();
    check("mid_bit3_tx", 32'(uart_tx), 32'd0);
    check("mid_level", 32'(level), 32'd1);
    #1;
    lpc_rst = 1'b0;
    #1;
    check("mid_rst_tx", 32'(uart_tx), 32'd1);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_thre", 32'(thre), 32'd1);
    check("mid_rst_temt", 32'(temt), 32'd1);
    tick();
    lpc_rst = 1'b1;
    wr_stb  = 1'b1;
    wr_data = 8'hA5;
    tick();
    check("rel2_edge1_level", 32'(level), 32'd0);
    tick();
    check("rel2_edge2_level", 32'(level), 32'd1);
    wr_stb = 1'b0;
    tick();
    check_frame("post_rst_a5", 8'hA5);
    check("post_rst_temt", 32'(temt), 32'd1);
    check("post_rst_level", 32'(level), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
